// File: rtl/rvvi_frame_arbiter.sv
// Frame-atomic arbiter sharing the outbound RVVI AXI4 write-data channel between the
// trace packetizer (source 0) and the host status generator (source 1).
module rvvi_frame_arbiter #(
    parameter int MAX_FRAME_WORDS = 32
) (
    input  logic        m_axi_aclk,
    input  logic        m_axi_aresetn,
    input  logic [31:0] Src0Wdata,
    input  logic [3:0]  Src0Wstrb,
    input  logic        Src0Wlast,
    input  logic        Src0Wvalid,
    output logic        Src0Wready,
    input  logic [31:0] Src1Wdata,
    input  logic [3:0]  Src1Wstrb,
    input  logic        Src1Wlast,
    input  logic        Src1Wvalid,
    output logic        Src1Wready,
    output logic [31:0] RvviAxiWdata,
    output logic [3:0]  RvviAxiWstrb,
    output logic        RvviAxiWlast,
    output logic        RvviAxiWvalid,
    input  logic        RvviAxiWready,
    input  logic [31:0] IfgCycles,
    input  logic        PrioMode,
    output logic [1:0]  Grant,
    output logic        Busy,
    output logic [31:0] FrameCount0,
    output logic [31:0] FrameCount1,
    output logic        FrameErr
);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    localparam logic [9:0] WDOG_LAST = 10'(MAX_FRAME_WORDS - 1);

    state_t      state;
    state_t      nextState;
    logic        lastServed;
    logic [9:0]  beatCount;
    logic [31:0] gapCnt;
    logic        pickSrc1;
    logic        srcLast;
    logic        watchdog;
    logic        beat;
    logic        frameDone;

    // lastServed is 1 when source 1 completed the most recent frame.
    always_comb begin
        pickSrc1 = 1'b0;
        if (Src1Wvalid && !Src0Wvalid) begin
            pickSrc1 = 1'b1;
        end else if (Src0Wvalid && Src1Wvalid && !PrioMode) begin
            pickSrc1 = ~lastServed;
        end
    end

    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (Src0Wvalid || Src1Wvalid) nextState = XFER;
            XFER: if (frameDone) nextState = (IfgCycles != 32'd0) ? GAP : IDLE;
            GAP:  if (gapCnt == 32'd1) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Passthrough of the granted source; everything is quiet outside XFER.
    always_comb begin
        RvviAxiWdata  = '0;
        RvviAxiWstrb  = '0;
        RvviAxiWlast  = 1'b0;
        RvviAxiWvalid = 1'b0;
        Src0Wready    = 1'b0;
        Src1Wready    = 1'b0;
        srcLast       = Grant[1] ? Src1Wlast : Src0Wlast;
        watchdog      = (state == XFER) && (beatCount == WDOG_LAST) && !srcLast;
        if (state == XFER) begin
            if (Grant[1]) begin
                RvviAxiWdata  = Src1Wdata;
                RvviAxiWstrb  = Src1Wstrb;
                RvviAxiWvalid = Src1Wvalid;
                Src1Wready    = RvviAxiWready;
            end else begin
                RvviAxiWdata  = Src0Wdata;
                RvviAxiWstrb  = Src0Wstrb;
                RvviAxiWvalid = Src0Wvalid;
                Src0Wready    = RvviAxiWready;
            end
            RvviAxiWlast = srcLast | watchdog;
        end
        beat      = RvviAxiWvalid & RvviAxiWready;
        frameDone = beat & RvviAxiWlast;
        Busy      = (state != IDLE);
    end

    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            Grant       <= 2'b00;
            lastServed  <= 1'b1;
            beatCount   <= '0;
            gapCnt      <= '0;
            FrameCount0 <= '0;
            FrameCount1 <= '0;
            FrameErr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Src0Wvalid || Src1Wvalid) begin
                        Grant     <= pickSrc1 ? 2'b10 : 2'b01;
                        beatCount <= '0;
                    end
                end
                XFER: begin
                    if (beat) begin
                        beatCount <= beatCount + 10'd1;
                        if (watchdog) FrameErr <= 1'b1;
                        if (frameDone) begin
                            if (Grant[1]) FrameCount1 <= FrameCount1 + 32'd1;
                            else          FrameCount0 <= FrameCount0 + 32'd1;
                            lastServed <= Grant[1];
                            Grant      <= 2'b00;
                            gapCnt     <= IfgCycles;
                        end
                    end
                end
                GAP: gapCnt <= gapCnt - 32'd1;
                default: ;
            endcase
        end
    end

endmodule
